dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory responder (IDLE -> BUSY -> RESP) with one-cycle ready pulse.
// Optional access checking (misaligned / out-of-range -> err) is compiled in by `define DMEM_RESPONDER_ERR_EN.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_start;
  logic          w_enter_resp;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_acc_idx;
  logic          w_acc_bad;

  // With LATENCY=1 the capture edge is also the edge entering RESP, so the live inputs are used there.
  assign w_start      = (r_state == IDLE) && req;
  assign w_enter_resp = (w_start && (LATENCY == 1)) || ((r_state == BUSY) && (r_cnt == 4'd1));
  assign w_acc_we     = w_start ? we    : r_we;
  assign w_acc_addr   = w_start ? addr  : r_addr;
  assign w_acc_wdata  = w_start ? wdata : r_wdata;
  assign w_acc_idx    = w_acc_addr[AW+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
  assign w_acc_bad = (w_acc_addr[1:0] != 2'b00) || (|w_acc_addr[31:AW+2]);
`else
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{w_acc_addr[31:AW+2], w_acc_addr[1:0]};
  assign w_acc_bad = 1'b0;
`endif

  // Sequencer, array and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp && w_acc_bad;
      if (w_enter_resp && !w_acc_bad) begin
        if (w_acc_we) begin
          r_mem[w_acc_idx] <= w_acc_wdata;
        end else begin
          r_rdata <= r_mem[w_acc_idx];
        end
      end
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY > 1) ? BUSY : RESP;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 15) sharing clock and reset.
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [3];
  logic        we_s    [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];
  int          lat_tab [3];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] rd;
  logic        e;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]));
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]));
  dmem_responder #(.DEPTH(64), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .reset(reset), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access; the capture edge counts as edge 1, ready must first appear after edge LATENCY.
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] o_rd, output logic o_e);
    int n;
    @(negedge clk);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    @(posedge clk); #1;
    req_s[k] = 1'b0; we_s[k] = ~w; addr_s[k] = ~a; wdata_s[k] = ~d;
    n = 1;
    while (!ready_s[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(lat_tab[k]));
    o_rd = rdata_s[k];
    o_e  = err_s[k];
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {31'd0, ready_s[k]}, 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int edges;
    lat_tab[0] = 2; lat_tab[1] = 1; lat_tab[2] = 15;
    for (int k = 0; k < 3; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", {31'd0, ready_s[k]}, 32'd0);
      check_eq("rst_err",   {31'd0, err_s[k]},   32'd0);
      check_eq("rst_rdata", rdata_s[k],          32'd0);
    end
    @(negedge clk); reset = 1'b1;

    // Store then load, plus rdata hold across a store and idle cycles.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, "st10", rd, e);
    check_eq("st10_err", {31'd0, e}, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, "ld10", rd, e);
    check_eq("ld10_rd", rd, 32'hDEADBEEF);
    check_eq("ld10_err", {31'd0, e}, 32'd0);
    access(0, 1'b1, 32'h14, 32'h11111111, "st14", rd, e);
    check_eq("hold_store", rd, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_idle", rdata_s[0], 32'hDEADBEEF);
    access(0, 1'b0, 32'h14, 32'h0, "ld14", rd, e);
    check_eq("ld14_rd", rd, 32'h11111111);

    // Latency extremes.
    access(1, 1'b1, 32'h3C, 32'h0F0F0F0F, "l1_st", rd, e);
    access(1, 1'b0, 32'h3C, 32'h0, "l1_ld", rd, e);
    check_eq("l1_rd", rd, 32'h0F0F0F0F);
    access(2, 1'b1, 32'h08, 32'h15151515, "l15_st", rd, e);
    access(2, 1'b0, 32'h08, 32'h0, "l15_ld", rd, e);
    check_eq("l15_rd", rd, 32'h15151515);

    // Held req with inputs changed after capture.
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h30; wdata_s[0] = 32'hCAFE0001;
    @(posedge clk); #1;
    addr_s[0] = 32'h34; wdata_s[0] = 32'hCAFE0002;
    n = 1;
    while (!ready_s[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("held_lat1", 32'(n), 32'd2);
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (!ready_s[0] && m < 40);
    check_eq("held_period", 32'(m), 32'd3);
    req_s[0] = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, 32'h30, 32'h0, "held_ld30", rd, e);
    check_eq("held_rd30", rd, 32'hCAFE0001);
    access(0, 1'b0, 32'h34, 32'h0, "held_ld34", rd, e);
    check_eq("held_rd34", rd, 32'hCAFE0002);

    // Reset during BUSY aborts the store and clears the array.
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h12345678;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rstbusy_ready", {31'd0, ready_s[0]}, 32'd0);
    end
    check_eq("rstbusy_rdata", rdata_s[0], 32'd0);
    @(negedge clk); reset = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, "rst_ld20", rd, e);
    check_eq("rst_rd20", rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, "rst_ld10", rd, e);
    check_eq("rst_rd10", rd, 32'h0);

    // Misaligned and out-of-range accesses.
    access(0, 1'b1, 32'h02, 32'hAAAA5555, "st_mis", rd, e);
    check_eq("st_mis_err", {31'd0, e}, {31'd0, ERR_ON});
    access(0, 1'b0, 32'h00, 32'h0, "ld_w0a", rd, e);
    check_eq("ld_w0a_rd", rd, ERR_ON ? 32'h0 : 32'hAAAA5555);
    check_eq("ld_w0a_err", {31'd0, e}, 32'd0);
    access(0, 1'b1, 32'h100, 32'h5555AAAA, "st_oor", rd, e);
    check_eq("st_oor_err", {31'd0, e}, {31'd0, ERR_ON});
    access(0, 1'b0, 32'h00, 32'h0, "ld_w0b", rd, e);
    check_eq("ld_w0b_rd", rd, ERR_ON ? 32'h0 : 32'h5555AAAA);
    access(0, 1'b0, 32'h100, 32'h0, "ld_oor", rd, e);
    check_eq("ld_oor_rd", rd, ERR_ON ? 32'h0 : 32'h5555AAAA);
    check_eq("ld_oor_err", {31'd0, e}, {31'd0, ERR_ON});

    // Back-to-back stores then loads over every word, req held high throughout.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = (pass == 0); addr_s[0] = 32'd0; wdata_s[0] = 32'd0;
      edges = 0;
      for (int i = 0; i < 64; i++) begin
        n = 0;
        do begin
          @(posedge clk); #1;
          edges++;
          n++;
        end while (!ready_s[0] && n < 40);
        if (pass == 1) begin
          check_eq("b2b_rd", rdata_s[0], 32'(i));
        end
        if (i < 63) begin
          addr_s[0] = 32'((i + 1) * 4);
          wdata_s[0] = 32'(i + 1);
        end else begin
          req_s[0] = 1'b0;
        end
      end
      check_eq("b2b_cycles", 32'(edges), 32'd191);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
